// File: rtl/stack_pkg.sv
// Shared constants, count-width helper and command encoding for the LIFO stack.
// Command code is the concatenation {push, pop}.
package stack_pkg;

    localparam int STACK_DATA_WIDTH = 8;
    localparam int STACK_DEPTH      = 16;

    // count spans 0..depth inclusive, hence one bit more than the address
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_POP  = 2'b01,
        CMD_PUSH = 2'b10,
        CMD_SWAP = 2'b11
    } cmd_e;

endpackage

// File: rtl/stack_ram.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// No reset; contents are unreachable until rewritten.
module stack_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with push/pop/swap, popped word registered (latency 1); no backpressure,
// illegal push-when-full / pop-when-empty rejected and pulsed on error. STACK_STATUS_EN adds empty/full/level.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = STACK_DATA_WIDTH,
    parameter int DEPTH      = STACK_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  error
`ifdef STACK_STATUS_EN
    ,
    output logic                         empty,
    output logic                         full,
    output logic [cnt_width(DEPTH)-1:0]  level
`endif
);

    localparam int CW = cnt_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_error;

    cmd_e                  w_cmd;
    logic                  w_empty;
    logic                  w_full;
    logic [AW-1:0]         w_top_addr;
    logic [DATA_WIDTH-1:0] w_top_data;
    logic                  w_we;
    logic [AW-1:0]         w_waddr;
    logic [CW-1:0]         w_count_nxt;
    logic [DATA_WIDTH-1:0] w_data_out_nxt;
    logic                  w_error_nxt;

    assign w_cmd   = cmd_e'({push, pop});
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    // Low bits wrap so a full stack still addresses DEPTH-1 as its top
    assign w_top_addr = r_count[AW-1:0] - AW'(1);

    stack_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (data_in),
        .i_raddr (w_top_addr),
        .o_rdata (w_top_data)
    );

    always_comb begin
        w_we           = 1'b0;
        w_waddr        = r_count[AW-1:0];
        w_count_nxt    = r_count;
        w_data_out_nxt = r_data_out;
        w_error_nxt    = 1'b0;
        case (w_cmd)
            CMD_PUSH: begin
                if (w_full) begin
                    w_error_nxt = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    w_count_nxt = r_count + CW'(1);
                end
            end
            CMD_POP: begin
                if (w_empty) begin
                    w_error_nxt = 1'b1;
                end else begin
                    w_data_out_nxt = w_top_data;
                    w_count_nxt    = r_count - CW'(1);
                end
            end
            CMD_SWAP: begin
                // Empty stack: the pushed word passes straight through to data_out
                if (w_empty) begin
                    w_data_out_nxt = data_in;
                end else begin
                    w_data_out_nxt = w_top_data;
                    w_we           = 1'b1;
                    w_waddr        = w_top_addr;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_data_out <= '0;
            r_error    <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_data_out <= w_data_out_nxt;
            r_error    <= w_error_nxt;
        end
    end

    assign data_out = r_data_out;
    assign error    = r_error;

`ifdef STACK_STATUS_EN
    assign empty = w_empty;
    assign full  = w_full;
    assign level = r_count;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed + random checks of lifo_stack against a queue-based reference model.
module tb_lifo_stack;
    import stack_pkg::*;

    localparam int DW    = STACK_DATA_WIDTH;
    localparam int DEPTH = STACK_DEPTH;
    localparam int CW    = cnt_width(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          error;
`ifdef STACK_STATUS_EN
    logic          empty;
    logic          full;
    logic [CW-1:0] level;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model [$];
    logic [DW-1:0] exp_dout;
    logic          exp_err;

    lifo_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .error    (error)
`ifdef STACK_STATUS_EN
        ,
        .empty    (empty),
        .full     (full),
        .level    (level)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"}, 32'(data_out), 32'(exp_dout));
        chk({tag, ".err"}, 32'(error), 32'(exp_err));
`ifdef STACK_STATUS_EN
        chk({tag, ".level"}, 32'(level), 32'(model.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(model.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(model.size() == DEPTH));
`endif
    endtask

    // Apply one command for one clock, update the model, then check outputs.
    task automatic step(input logic p, input logic q, input logic [DW-1:0] d, input string tag);
        push = p; pop = q; data_in = d;
        @(posedge clk); #1;
        exp_err = 1'b0;
        if (p && !q) begin
            if (model.size() < DEPTH) model.push_back(d);
            else exp_err = 1'b1;
        end else if (q && !p) begin
            if (model.size() > 0) exp_dout = model.pop_back();
            else exp_err = 1'b1;
        end else if (p && q) begin
            if (model.size() > 0) begin
                exp_dout = model[$];
                model[$] = d;
            end else begin
                exp_dout = d;
            end
        end
        push = 1'b0; pop = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        exp_dout = '0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        reset = 1'b0;

        step(1, 0, 8'hAA, "t2.push");
        step(0, 0, 8'h00, "t2.idle1");
        step(0, 0, 8'h00, "t2.idle2");
        step(0, 1, 8'h00, "t2.pop");

        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i), "t3.fill");
        step(1, 0, 8'hFF, "t3.overflow");
        step(0, 0, 8'h00, "t3.err_clear");
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, "t3.drain");

        step(1, 0, 8'h11, "t5.push");
        step(1, 1, 8'h22, "t5.swap");
        step(0, 1, 8'h00, "t5.pop");
        step(1, 1, 8'h33, "t5.bypass");

        step(0, 1, 8'h00, "t4.underflow");
        step(0, 0, 8'h00, "t4.err_clear");

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), DW'($urandom), "rand");
        end

        step(1, 0, 8'h5A, "t6.push1");
        step(1, 0, 8'hC3, "t6.push2");
        step(1, 0, 8'h7E, "t6.push3");
        step(0, 1, 8'h00, "t6.pop");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        model.delete();
        exp_dout = '0; exp_err = 1'b0;
        chk_all("t6.async_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        step(0, 1, 8'h00, "t6.pop_after_reset");
        step(0, 0, 8'h00, "t6.idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
